// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the Gamepad Pmod serial link (transmitter and receiver).
// Button bit positions, frame sizes, FSM state encoding and frame-word helper.
package gamepad_pmod_pkg;

    localparam int GP_BITS       = 12;
    localparam int GP_FRAME_BITS = 24;

    localparam int GP_B      = 11;
    localparam int GP_Y      = 10;
    localparam int GP_SELECT = 9;
    localparam int GP_START  = 8;
    localparam int GP_UP     = 7;
    localparam int GP_DOWN   = 6;
    localparam int GP_LEFT   = 5;
    localparam int GP_RIGHT  = 4;
    localparam int GP_A      = 3;
    localparam int GP_X      = 2;
    localparam int GP_L      = 1;
    localparam int GP_R      = 0;

    localparam logic [GP_BITS-1:0] GP_ABSENT = 12'hFFF;

    typedef enum logic [2:0] {
        GP_IDLE     = 3'd0,
        GP_LATCH    = 3'd1,
        GP_SHIFT_LO = 3'd2,
        GP_SHIFT_HI = 3'd3,
        GP_GAP      = 3'd4
    } gp_state_t;

    function automatic int gp_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // An unplugged controller reads as all ones on the wire.
    function automatic logic [GP_FRAME_BITS-1:0] gp_frame_word(
        input logic [GP_BITS-1:0] b1,
        input logic [GP_BITS-1:0] b2,
        input logic               p1,
        input logic               p2
    );
        return {(p1 ? b1 : GP_ABSENT), (p2 ? b2 : GP_ABSENT)};
    endfunction

endpackage

// File: rtl/gamepad_pmod_tx.sv
// Transmit end of the Gamepad Pmod link: serialises two 12-bit controller words
// MSB first on pmod_latch/pmod_clk/pmod_data; all outputs are registered.
module gamepad_pmod_tx
    import gamepad_pmod_pkg::*;
#(
    parameter int HALF_DIV     = 4,
    parameter int LATCH_CYCLES = 8,
    parameter int GAP_CYCLES   = 16,
    parameter int FREE_RUN     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [GP_BITS-1:0] btn1,
    input  logic [GP_BITS-1:0] btn2,
    input  logic               present1,
    input  logic               present2,
    output logic               pmod_latch,
    output logic               pmod_clk,
    output logic               pmod_data,
    output logic               busy,
    output logic               done,
    output gp_state_t          dbg_state
);

    localparam int CW = $clog2(gp_max3(HALF_DIV, LATCH_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    gp_state_t                r_state;
    logic [CW-1:0]            r_cnt;
    logic [4:0]               r_idx;
    logic [GP_FRAME_BITS-1:0] r_word;
    logic                     r_latch;
    logic                     r_pclk;
    logic                     r_data;
    logic                     r_busy;
    logic                     r_done;

    gp_state_t                w_state_nx;
    logic [CW-1:0]            w_cnt_nx;
    logic [4:0]               w_idx_nx;
    logic [GP_FRAME_BITS-1:0] w_word_nx;
    logic                     w_done_nx;
    logic                     w_shifting_nx;

    // r_busy is still high in the done cycle, which is what makes a start
    // arriving alongside done get ignored.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_word_nx  = r_word;
        w_done_nx  = 1'b0;
        unique case (r_state)
            GP_IDLE: begin
                if ((FREE_RUN != 0) || (start && !r_busy)) begin
                    w_state_nx = GP_LATCH;
                    w_cnt_nx   = LATCH_LOAD;
                    w_word_nx  = gp_frame_word(btn1, btn2, present1, present2);
                end
            end
            GP_LATCH: begin
                if (r_cnt == '0) begin
                    w_state_nx = GP_SHIFT_LO;
                    w_cnt_nx   = HALF_LOAD;
                    w_idx_nx   = 5'(GP_FRAME_BITS - 1);
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            GP_SHIFT_LO: begin
                if (r_cnt == '0) begin
                    w_state_nx = GP_SHIFT_HI;
                    w_cnt_nx   = HALF_LOAD;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            GP_SHIFT_HI: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else if (r_idx != 5'd0) begin
                    w_state_nx = GP_SHIFT_LO;
                    w_cnt_nx   = HALF_LOAD;
                    w_idx_nx   = r_idx - 5'd1;
                end else if (GAP_CYCLES == 0) begin
                    w_state_nx = GP_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_state_nx = GP_GAP;
                    w_cnt_nx   = GAP_LOAD;
                end
            end
            GP_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nx = GP_IDLE;
                    w_done_nx  = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nx = GP_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        w_shifting_nx = (w_state_nx == GP_SHIFT_LO) || (w_state_nx == GP_SHIFT_HI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= GP_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_latch <= 1'b0;
            r_pclk  <= 1'b0;
            r_data  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_word  <= w_word_nx;
            r_latch <= (w_state_nx == GP_LATCH);
            r_pclk  <= (w_state_nx == GP_SHIFT_HI);
            r_data  <= w_shifting_nx ? w_word_nx[w_idx_nx] : 1'b0;
            r_busy  <= (w_state_nx != GP_IDLE) || w_done_nx;
            r_done  <= w_done_nx;
        end
    end

    assign pmod_latch = r_latch;
    assign pmod_clk   = r_pclk;
    assign pmod_data  = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Bench for gamepad_pmod_tx: loopback into a small receiver model, link timing,
// start filtering, mid-frame reset and free-running frame period.
module tb_gamepad_pmod_tx;
    import gamepad_pmod_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instance A: default parameters, used for loopback scenarios.
    logic        a_start = 1'b0, a_p1 = 1'b1, a_p2 = 1'b1;
    logic [11:0] a_btn1 = '0, a_btn2 = '0;
    logic        a_latch, a_clk, a_data, a_busy, a_done;
    gp_state_t   a_state;

    gamepad_pmod_tx u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .btn1(a_btn1), .btn2(a_btn2),
        .present1(a_p1), .present2(a_p2), .pmod_latch(a_latch), .pmod_clk(a_clk),
        .pmod_data(a_data), .busy(a_busy), .done(a_done), .dbg_state(a_state)
    );

    // Instance T: short timing configuration.
    logic        t_start = 1'b0;
    logic [11:0] t_btn1 = 12'h5A5, t_btn2 = 12'h3C3;
    logic        t_latch, t_clk, t_data, t_busy, t_done;
    gp_state_t   t_state;

    gamepad_pmod_tx #(.HALF_DIV(2), .LATCH_CYCLES(3), .GAP_CYCLES(5)) u_dut_t (
        .clk(clk), .rst_n(rst_n), .start(t_start), .btn1(t_btn1), .btn2(t_btn2),
        .present1(1'b1), .present2(1'b1), .pmod_latch(t_latch), .pmod_clk(t_clk),
        .pmod_data(t_data), .busy(t_busy), .done(t_done), .dbg_state(t_state)
    );

    // Instance F: free-running, period 1+2+48*1+3 = 54.
    logic        f_latch, f_clk, f_data, f_busy, f_done;
    gp_state_t   f_state;

    gamepad_pmod_tx #(.HALF_DIV(1), .LATCH_CYCLES(2), .GAP_CYCLES(3), .FREE_RUN(1)) u_dut_f (
        .clk(clk), .rst_n(rst_n), .start(1'b0), .btn1(12'h123), .btn2(12'h456),
        .present1(1'b1), .present2(1'b1), .pmod_latch(f_latch), .pmod_clk(f_clk),
        .pmod_data(f_data), .busy(f_busy), .done(f_done), .dbg_state(f_state)
    );

    // Receiver model for A: latch clears, each pmod_clk rising edge shifts in one bit.
    logic [23:0] rx_a = '0;
    int          edges_a = 0;
    logic        a_clk_q = 1'b0;
    always @(negedge clk) begin
        if (a_latch) begin
            rx_a    <= '0;
            edges_a <= 0;
        end else if (a_clk && !a_clk_q) begin
            rx_a    <= {rx_a[22:0], a_data};
            edges_a <= edges_a + 1;
        end
        a_clk_q <= a_clk;
    end

    function automatic logic rx_present(input logic [11:0] w);
        return w != 12'hFFF;
    endfunction

    // Link-timing monitor for T.
    logic t_clr = 1'b0;
    int   t_busy_cnt = 0, t_edges = 0, t_done_cnt = 0, t_viol = 0, t_overlap = 0;
    logic t_clk_q = 1'b0, t_data_q = 1'b0;
    always @(negedge clk) begin
        if (t_clr) begin
            t_busy_cnt <= 0; t_edges <= 0; t_done_cnt <= 0; t_viol <= 0; t_overlap <= 0;
        end else begin
            if (t_busy) t_busy_cnt <= t_busy_cnt + 1;
            if (t_done) t_done_cnt <= t_done_cnt + 1;
            if (t_clk && !t_clk_q) t_edges <= t_edges + 1;
            if ((t_data != t_data_q) && (t_clk || t_latch)) t_viol <= t_viol + 1;
            if (t_clk && t_latch) t_overlap <= t_overlap + 1;
        end
        t_clk_q  <= t_clk;
        t_data_q <= t_data;
    end

    task automatic pulse_a_start();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (a_done) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL %s: done not seen within %0d cycles", name, budget);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_latch, a_clk, a_data, a_busy, a_done} !== 5'b0)
            $display("FAIL reset_a: outputs=%b expected 00000", {a_latch, a_clk, a_data, a_busy, a_done});
        else n_pass++;
        n_checks++;
        if (a_state !== GP_IDLE) $display("FAIL reset_a_state: got %0d expected %0d", a_state, GP_IDLE);
        else n_pass++;
        n_checks++;
        if ({t_latch, t_clk, t_data, t_busy, t_done} !== 5'b0)
            $display("FAIL reset_t: outputs=%b expected 00000", {t_latch, t_clk, t_data, t_busy, t_done});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loopback();
        a_btn1 = 12'h0A5; a_btn2 = 12'h300; a_p1 = 1'b1; a_p2 = 1'b1;
        pulse_a_start();
        wait_done_a(400, "loopback_done");
        n_checks++;
        if (rx_a !== 24'h0A5300) $display("FAIL loopback_word: got %h expected 0a5300", rx_a);
        else n_pass++;
        n_checks++;
        if (edges_a !== 24) $display("FAIL loopback_edges: got %0d expected 24", edges_a);
        else n_pass++;
        n_checks++;
        if (rx_present(rx_a[23:12]) !== 1'b1 || rx_a[23:12] !== 12'h0A5)
            $display("FAIL loopback_ctrl1: present=%b buttons=%h expected 1/0a5",
                     rx_present(rx_a[23:12]), rx_a[23:12]);
        else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_absent();
        logic [11:0] btns;
        a_btn1 = 12'h000; a_btn2 = 12'h81F; a_p1 = 1'b0; a_p2 = 1'b1;
        pulse_a_start();
        wait_done_a(400, "absent_done");
        n_checks++;
        if (rx_a[23:12] !== 12'hFFF) $display("FAIL absent_bits: got %h expected fff", rx_a[23:12]);
        else n_pass++;
        btns = rx_present(rx_a[23:12]) ? rx_a[23:12] : 12'h000;
        n_checks++;
        if (rx_present(rx_a[23:12]) !== 1'b0 || btns !== 12'h000)
            $display("FAIL absent_ctrl1: present=%b buttons=%h expected 0/000",
                     rx_present(rx_a[23:12]), btns);
        else n_pass++;
        n_checks++;
        if (rx_a[11:0] !== 12'h81F) $display("FAIL absent_ctrl2: got %h expected 81f", rx_a[11:0]);
        else n_pass++;
        a_p1 = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timing();
        bit seen = 1'b0;
        @(negedge clk);
        t_clr = 1'b1;
        @(negedge clk);
        t_clr = 1'b0;
        t_start = 1'b1;
        @(negedge clk);
        t_start = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (t_done) seen = 1'b1;
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (!seen) $display("FAIL timing_done: done not seen within 300 cycles");
        else n_pass++;
        n_checks++;
        if (t_busy_cnt !== 105) $display("FAIL timing_busy: got %0d cycles expected 105", t_busy_cnt);
        else n_pass++;
        n_checks++;
        if (t_edges !== 24) $display("FAIL timing_edges: got %0d expected 24", t_edges);
        else n_pass++;
        n_checks++;
        if (t_done_cnt !== 1) $display("FAIL timing_done_width: got %0d expected 1", t_done_cnt);
        else n_pass++;
        n_checks++;
        if (t_viol !== 0) $display("FAIL timing_data_stable: got %0d toggles expected 0", t_viol);
        else n_pass++;
        n_checks++;
        if (t_overlap !== 0) $display("FAIL timing_latch_clk: got %0d overlaps expected 0", t_overlap);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int busy_after = 0;
        int edges_after;
        bit reached = 1'b0;
        a_btn1 = 12'h5A3; a_btn2 = 12'h0F0;
        pulse_a_start();
        for (int i = 0; i < 400 && !reached; i++) begin
            @(negedge clk);
            if (edges_a == 13) reached = 1'b1;
        end
        n_checks++;
        if (!reached) $display("FAIL b2b_bit10: edge 13 not reached, edges=%0d", edges_a);
        else n_pass++;
        a_btn1 = 12'hFFE;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_done_a(400, "b2b_done");
        // Start raised in the done cycle must be dropped, not queued.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        n_checks++;
        if (rx_a !== 24'h5A30F0) $display("FAIL b2b_word: got %h expected 5a30f0", rx_a);
        else n_pass++;
        edges_after = edges_a;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (a_busy) busy_after++;
        end
        n_checks++;
        if (busy_after !== 0 || edges_a !== edges_after)
            $display("FAIL b2b_no_second: busy_cycles=%0d edges=%0d expected 0/%0d",
                     busy_after, edges_a, edges_after);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        a_btn1 = 12'hFFF; a_btn2 = 12'hFFF;
        pulse_a_start();
        for (int i = 0; i < 400 && !reached; i++) begin
            @(negedge clk);
            if (edges_a == 17) reached = 1'b1;
        end
        n_checks++;
        if (!reached || a_state !== GP_SHIFT_HI || a_clk !== 1'b1)
            $display("FAIL midrst_setup: reached=%b state=%0d clk=%b expected 1/%0d/1",
                     reached, a_state, a_clk, GP_SHIFT_HI);
        else n_pass++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({a_latch, a_clk, a_data, a_busy, a_done} !== 5'b0 || a_state !== GP_IDLE)
            $display("FAIL midrst_outputs: outputs=%b state=%0d expected 00000/%0d",
                     {a_latch, a_clk, a_data, a_busy, a_done}, a_state, GP_IDLE);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        a_btn1 = 12'h3C5; a_btn2 = 12'hA5A;
        pulse_a_start();
        wait_done_a(400, "midrst_done");
        n_checks++;
        if (rx_a !== 24'h3C5A5A || edges_a !== 24)
            $display("FAIL midrst_fresh: got %h/%0d edges expected 3c5a5a/24", rx_a, edges_a);
        else n_pass++;
    endtask

    task automatic test_free_run();
        int times[$];
        int cyc = 0;
        int doubles = 0;
        logic done_q = 1'b0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            cyc++;
            if (f_done) times.push_back(cyc);
            if (f_done && done_q) doubles++;
            done_q = f_done;
        end
        n_checks++;
        if (times.size() < 4) $display("FAIL free_count: got %0d done pulses expected >=4", times.size());
        else n_pass++;
        for (int k = 1; k < 4 && k < times.size(); k++) begin
            n_checks++;
            if (times[k] - times[k-1] !== 54)
                $display("FAIL free_period%0d: got %0d expected 54", k, times[k] - times[k-1]);
            else n_pass++;
        end
        n_checks++;
        if (doubles !== 0) $display("FAIL free_done_width: got %0d wide pulses expected 0", doubles);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_absent();
        test_timing();
        test_back_to_back();
        test_reset_mid();
        test_free_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
